// File: rtl/pact_core_sequencer_pkg.sv
// Shared definitions for the PACT core sequencer: subop codes, immediate width,
// state encoding and the default watchdog limit.
package pact_core_sequencer_pkg;

    localparam int BW_PACT_SUBOP                 = 4;
    localparam int BW_PACT_IMMEDIATE             = 32;
    localparam int BW_PACT_CORE_SEQ_STATE        = 4;
    localparam int PACT_CORE_SEQ_TIMEOUT_DEFAULT = 65535;

    localparam logic [BW_PACT_SUBOP-1:0] PACT_SUBOP_CORE_IDLE      = 4'h0;
    localparam logic [BW_PACT_SUBOP-1:0] PACT_SUBOP_CORE_STARTADDR = 4'h1;
    localparam logic [BW_PACT_SUBOP-1:0] PACT_SUBOP_CORE_ACTIVE    = 4'h2;
    localparam logic [BW_PACT_SUBOP-1:0] PACT_SUBOP_CORE_WAIT      = 4'h3;

    typedef enum logic [BW_PACT_CORE_SEQ_STATE-1:0] {
        PACT_CORE_SEQ_IDLE       = 4'd0,
        PACT_CORE_SEQ_ISSUE_ADDR = 4'd1,
        PACT_CORE_SEQ_WAIT_ADDR  = 4'd2,
        PACT_CORE_SEQ_ISSUE_ACT  = 4'd3,
        PACT_CORE_SEQ_WAIT_ACT   = 4'd4,
        PACT_CORE_SEQ_ISSUE_WAIT = 4'd5,
        PACT_CORE_SEQ_WAIT_WAIT  = 4'd6,
        PACT_CORE_SEQ_DONE       = 4'd7,
        PACT_CORE_SEQ_DRAIN      = 4'd8
    } seq_state_t;

    // Subop held toward the node in each state; DRAIN keeps WAIT since the node is still busy.
    function automatic logic [BW_PACT_SUBOP-1:0] seq_subop(input seq_state_t s);
        case (s)
            PACT_CORE_SEQ_ISSUE_ADDR, PACT_CORE_SEQ_WAIT_ADDR: seq_subop = PACT_SUBOP_CORE_STARTADDR;
            PACT_CORE_SEQ_ISSUE_ACT,  PACT_CORE_SEQ_WAIT_ACT:  seq_subop = PACT_SUBOP_CORE_ACTIVE;
            PACT_CORE_SEQ_ISSUE_WAIT, PACT_CORE_SEQ_WAIT_WAIT,
            PACT_CORE_SEQ_DRAIN:                               seq_subop = PACT_SUBOP_CORE_WAIT;
            default:                                           seq_subop = PACT_SUBOP_CORE_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/pact_rr_arbiter.sv
// Combinational round-robin arbiter: lowest requesting index at or after ptr wins,
// with wrap-around. The pointer register is owned by the caller.
module pact_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   index
);

    int  cand;
    logic found;

    always_comb begin
        grant = '0;
        index = '0;
        found = 1'b0;
        cand  = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = int'(ptr) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                index       = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/pact_core_sequencer.sv
// Shares the PACT core node among NUM_REQ requesters and issues STARTADDR/ACTIVE/WAIT per grant.
// Optional WAIT-phase watchdog with DRAIN state: define PACT_CORE_SEQ_TIMEOUT_EN.
module pact_core_sequencer
    import pact_core_sequencer_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int BW_ADDR        = 32,
    parameter int TIMEOUT_CYCLES = PACT_CORE_SEQ_TIMEOUT_DEFAULT
) (
    input  logic                         clk,
    input  logic                         rstp,
    input  logic                         enable,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*BW_ADDR-1:0]   req_addr,
    output logic [NUM_REQ-1:0]           done_valid,
    output logic                         done_error,
    output logic                         busy,
    output logic                         core_start,
    input  logic                         core_finish,
    output logic [BW_PACT_SUBOP-1:0]     core_subop,
    output logic                         core_is_float,
    output logic [BW_PACT_IMMEDIATE-1:0] core_immediate
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    if (NUM_REQ < 1 || NUM_REQ > 16 || BW_ADDR > BW_PACT_IMMEDIATE ||
        TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_param_check
        $error("pact_core_sequencer: illegal parameter set");
    end

    seq_state_t                   state_reg, state_next;
    logic [IDX_W-1:0]             rr_ptr_reg, owner_reg;
    logic [BW_PACT_IMMEDIATE-1:0] addr_reg;
    logic [NUM_REQ-1:0]           arb_grant;
    logic [IDX_W-1:0]             arb_index, ptr_next;
    logic [BW_ADDR-1:0]           addr_slot [NUM_REQ];
    logic                         grant_fire;

`ifdef PACT_CORE_SEQ_TIMEOUT_EN
    logic [15:0] timer_reg;
    logic        error_reg;
    logic        timer_expired;
    assign timer_expired = ({1'b0, timer_reg} + 17'd1) >= 17'(TIMEOUT_CYCLES);
`endif

    pact_rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_arb (
        .req   (req_valid),
        .ptr   (rr_ptr_reg),
        .grant (arb_grant),
        .index (arb_index)
    );

    genvar gi;
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_slot
        assign addr_slot[gi]  = req_addr[gi*BW_ADDR +: BW_ADDR];
        assign done_valid[gi] = (state_reg == PACT_CORE_SEQ_DONE) && (owner_reg == IDX_W'(gi));
    end

    assign grant_fire = (state_reg == PACT_CORE_SEQ_IDLE) && enable && (|req_valid);
    assign req_ready  = grant_fire ? arb_grant : '0;
    assign ptr_next   = (arb_index == IDX_W'(NUM_REQ - 1)) ? '0 : arb_index + 1'b1;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            PACT_CORE_SEQ_IDLE:       if (grant_fire)  state_next = PACT_CORE_SEQ_ISSUE_ADDR;
            PACT_CORE_SEQ_ISSUE_ADDR:                  state_next = PACT_CORE_SEQ_WAIT_ADDR;
            PACT_CORE_SEQ_WAIT_ADDR:  if (core_finish) state_next = PACT_CORE_SEQ_ISSUE_ACT;
            PACT_CORE_SEQ_ISSUE_ACT:                   state_next = PACT_CORE_SEQ_WAIT_ACT;
            PACT_CORE_SEQ_WAIT_ACT:   if (core_finish) state_next = PACT_CORE_SEQ_ISSUE_WAIT;
            PACT_CORE_SEQ_ISSUE_WAIT:                  state_next = PACT_CORE_SEQ_WAIT_WAIT;
`ifdef PACT_CORE_SEQ_TIMEOUT_EN
            PACT_CORE_SEQ_WAIT_WAIT:  if (core_finish || timer_expired) state_next = PACT_CORE_SEQ_DONE;
            // A late finish landing exactly in DONE already releases the node, so skip DRAIN.
            PACT_CORE_SEQ_DONE:       state_next = (error_reg && !core_finish) ? PACT_CORE_SEQ_DRAIN
                                                                               : PACT_CORE_SEQ_IDLE;
            PACT_CORE_SEQ_DRAIN:      if (core_finish) state_next = PACT_CORE_SEQ_IDLE;
`else
            PACT_CORE_SEQ_WAIT_WAIT:  if (core_finish) state_next = PACT_CORE_SEQ_DONE;
            PACT_CORE_SEQ_DONE:                        state_next = PACT_CORE_SEQ_IDLE;
`endif
            default:                                   state_next = PACT_CORE_SEQ_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rstp) begin
            state_reg  <= PACT_CORE_SEQ_IDLE;
            rr_ptr_reg <= '0;
            owner_reg  <= '0;
            addr_reg   <= '0;
        end else begin
            state_reg <= state_next;
            if (grant_fire) begin
                rr_ptr_reg <= ptr_next;
                owner_reg  <= arb_index;
                addr_reg   <= BW_PACT_IMMEDIATE'(addr_slot[arb_index]);
            end
        end
    end

`ifdef PACT_CORE_SEQ_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rstp) begin
            timer_reg <= '0;
            error_reg <= 1'b0;
        end else begin
            if (state_reg == PACT_CORE_SEQ_ISSUE_WAIT) begin
                timer_reg <= '0;
            end else if (state_reg == PACT_CORE_SEQ_WAIT_WAIT) begin
                timer_reg <= timer_reg + 16'd1;
            end
            if (grant_fire) begin
                error_reg <= 1'b0;
            end else if (state_reg == PACT_CORE_SEQ_WAIT_WAIT && !core_finish && timer_expired) begin
                error_reg <= 1'b1;
            end
        end
    end
    assign done_error = (state_reg == PACT_CORE_SEQ_DONE) && error_reg;
`else
    assign done_error = 1'b0;
`endif

    assign busy           = (state_reg != PACT_CORE_SEQ_IDLE);
    assign core_start     = (state_reg == PACT_CORE_SEQ_ISSUE_ADDR) ||
                            (state_reg == PACT_CORE_SEQ_ISSUE_ACT)  ||
                            (state_reg == PACT_CORE_SEQ_ISSUE_WAIT);
    assign core_subop     = seq_subop(state_reg);
    assign core_is_float  = 1'b0;
    assign core_immediate = addr_reg;

endmodule

// File: tb/tb_pact_core_sequencer.sv
// Directed self-checking bench for pact_core_sequencer with a small node responder.
// The watchdog scenario runs only when PACT_CORE_SEQ_TIMEOUT_EN is defined.
module tb_pact_core_sequencer;
    import pact_core_sequencer_pkg::*;

    localparam int N  = 4;
    localparam int BA = 32;

    logic                         clk = 1'b0;
    logic                         rstp = 1'b1;
    logic                         enable = 1'b0;
    logic [N-1:0]                 req_valid = '0;
    logic [N*BA-1:0]              req_addr = '0;
    logic                         core_finish = 1'b0;
    logic [N-1:0]                 req_ready, done_valid;
    logic                         done_error, busy, core_start, core_is_float;
    logic [BW_PACT_SUBOP-1:0]     core_subop;
    logic [BW_PACT_IMMEDIATE-1:0] core_immediate;

    int nchk  = 0;
    int nfail = 0;
    int d_addr = 0, d_act = 0, d_wait = 0;

    pact_core_sequencer #(.NUM_REQ(N), .BW_ADDR(BA), .TIMEOUT_CYCLES(10)) dut (
        .clk(clk), .rstp(rstp), .enable(enable), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .done_valid(done_valid), .done_error(done_error), .busy(busy),
        .core_start(core_start), .core_finish(core_finish), .core_subop(core_subop),
        .core_is_float(core_is_float), .core_immediate(core_immediate)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Node responder: raises finish for one cycle, a programmable number of cycles after each start.
    logic pending = 1'b0;
    int   cnt = 0;
    always @(negedge clk) begin
        if (rstp) begin
            core_finish = 1'b0;
            pending     = 1'b0;
        end else begin
            if (core_finish) begin
                core_finish = 1'b0;
                pending     = 1'b0;
            end else if (pending) begin
                if (cnt == 0) core_finish = 1'b1;
                else          cnt = cnt - 1;
            end
            if (core_start) begin
                pending = 1'b1;
                cnt = (core_subop == PACT_SUBOP_CORE_STARTADDR) ? d_addr :
                      (core_subop == PACT_SUBOP_CORE_ACTIVE)    ? d_act  : d_wait;
            end
        end
    end

    // Protocol monitor: start pulse shape, three starts per grant, completion owner.
    logic         prev_start = 1'b0;
    int           starts = 0;
    logic [N-1:0] last_grant = '0;
    always @(posedge clk) begin
        if (rstp) begin
            prev_start = 1'b0;
            starts     = 0;
        end else begin
            if (core_start) begin
                chk("start_pulse_width", {63'd0, prev_start}, 64'd0);
                chk("start_vs_finish", {63'd0, core_finish}, 64'd0);
                starts++;
            end
            if (req_ready != '0) begin
                last_grant = req_ready;
                starts     = 0;
            end
            if (done_valid != '0) begin
                chk("done_owner", 64'(done_valid), 64'(last_grant));
                chk("starts_per_grant", 64'(starts), 64'd3);
            end
            prev_start = core_start;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, 64'(req_ready), 64'd0);
        chk({tag, "_done_valid"}, 64'(done_valid), 64'd0);
        chk({tag, "_done_error"}, 64'(done_error), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_core_start"}, 64'(core_start), 64'd0);
        chk({tag, "_core_subop"}, 64'(core_subop), 64'(PACT_SUBOP_CORE_IDLE));
        chk({tag, "_core_is_float"}, 64'(core_is_float), 64'd0);
        chk({tag, "_core_immediate"}, 64'(core_immediate), 64'd0);
    endtask

    // Returns in the grant cycle (T0); an expired budget is reported as a failed comparison.
    task automatic wait_ready(input int budget, output logic [N-1:0] g);
        int waited;
        waited = 0;
        g = '0;
        while (1) begin
            #1;
            if (req_ready != '0) begin
                g = req_ready;
                break;
            end
            if (waited >= budget) break;
            tick();
            waited++;
        end
        chk("wait_ready_in_budget", {63'd0, (g != '0)}, 64'd1);
    endtask

    // Counts cycles from the call until done_valid appears.
    task automatic wait_done(input int budget, output logic [N-1:0] g, output int lat);
        lat = 0;
        g = '0;
        while (lat < budget) begin
            tick();
            lat++;
            #1;
            if (done_valid != '0) begin
                g = done_valid;
                break;
            end
        end
        chk("wait_done_in_budget", {63'd0, (g != '0)}, 64'd1);
    endtask

    initial begin
        logic [N-1:0] g;
        logic [N-1:0] exp_order [5];
        int           lat;
        int           drain;

        // Reset state
        tick(); tick(); tick();
        rstp = 1'b0;
        #1;
        check_reset_outputs("reset");

        // Single request, WAIT phase finishes after 5 busy cycles
        d_addr = 0; d_act = 0; d_wait = 5;
        enable = 1'b1;
        req_valid = 4'b0001;
        req_addr[0*BA +: BA] = 32'h8000_0100;
        #1;
        chk("t0_req_ready", 64'(req_ready), 64'h1);
        tick(); req_valid = '0; #1;
        chk("t1_start", 64'(core_start), 64'd1);
        chk("t1_subop", 64'(core_subop), 64'(PACT_SUBOP_CORE_STARTADDR));
        chk("t1_imm", 64'(core_immediate), 64'h8000_0100);
        chk("t1_busy", 64'(busy), 64'd1);
        tick(); #1;
        chk("t2_start", 64'(core_start), 64'd0);
        chk("t2_subop", 64'(core_subop), 64'(PACT_SUBOP_CORE_STARTADDR));
        tick(); #1;
        chk("t3_start", 64'(core_start), 64'd1);
        chk("t3_subop", 64'(core_subop), 64'(PACT_SUBOP_CORE_ACTIVE));
        tick(); #1;
        chk("t4_start", 64'(core_start), 64'd0);
        tick(); #1;
        chk("t5_start", 64'(core_start), 64'd1);
        chk("t5_subop", 64'(core_subop), 64'(PACT_SUBOP_CORE_WAIT));
        for (int t = 6; t <= 11; t++) begin
            tick(); #1;
            chk("t6_11_no_done", 64'(done_valid), 64'd0);
        end
        tick(); #1;
        chk("t12_done_valid", 64'(done_valid), 64'h1);
        chk("t12_done_error", 64'(done_error), 64'd0);
        tick(); #1;
        chk("t13_busy", 64'(busy), 64'd0);
        chk("t13_imm_held", 64'(core_immediate), 64'h8000_0100);

        // All four requesting continuously from reset: order 0,1,2,3,0 with 7-cycle latency
        rstp = 1'b1;
        tick();
        rstp = 1'b0;
        d_wait = 0;
        req_valid = 4'b1111;
        exp_order[0] = 4'b0001; exp_order[1] = 4'b0010; exp_order[2] = 4'b0100;
        exp_order[3] = 4'b1000; exp_order[4] = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            wait_ready(10, g);
            chk("rr_grant", 64'(g), 64'(exp_order[i]));
            wait_done(20, g, lat);
            chk("rr_done", 64'(g), 64'(exp_order[i]));
            chk("rr_latency", 64'(lat), 64'd7);
        end

        // enable low blocks grants
        tick();
        enable = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1;
            chk("disabled_req_ready", 64'(req_ready), 64'd0);
            chk("disabled_busy", 64'(busy), 64'd0);
            tick();
        end

        // enable dropped mid-chain: chain completes, then no further grant
        enable = 1'b1;
        wait_ready(5, g);
        chk("resume_grant", 64'(g), 64'b0010);
        tick();
        enable = 1'b0;
        wait_done(20, g, lat);
        chk("midchain_done", 64'(g), 64'b0010);
        for (int i = 0; i < 10; i++) begin
            tick(); #1;
            chk("after_chain_req_ready", 64'(req_ready), 64'd0);
            chk("after_chain_busy", 64'(busy), 64'd0);
        end

        // Reset during WAIT_ACT
        req_valid = 4'b0100;
        req_addr[2*BA +: BA] = 32'h1234_5678;
        enable = 1'b1;
        d_act = 50;
        wait_ready(5, g);
        chk("rst_case_grant", 64'(g), 64'b0100);
        tick(); req_valid = '0;
        tick(); tick(); tick(); #1;
        chk("wait_act_subop", 64'(core_subop), 64'(PACT_SUBOP_CORE_ACTIVE));
        chk("wait_act_start", 64'(core_start), 64'd0);
        rstp = 1'b1;
        tick();
        rstp = 1'b0;
        #1;
        check_reset_outputs("midreset");
        for (int i = 0; i < 3; i++) begin
            tick(); #1;
            chk("midreset_no_done", 64'(done_valid), 64'd0);
        end
        d_act = 0;
        req_valid = 4'b0100;
        req_addr[2*BA +: BA] = 32'h0000_00AB;
        wait_ready(5, g);
        chk("post_reset_grant", 64'(g), 64'b0100);
        tick(); req_valid = '0; #1;
        chk("post_reset_imm", 64'(core_immediate), 64'h0000_00AB);
        wait_done(20, g, lat);
        chk("post_reset_done", 64'(g), 64'b0100);

`ifdef PACT_CORE_SEQ_TIMEOUT_EN
        // Watchdog: finish withheld 30 cycles; done_error after 10 WAIT cycles, then DRAIN
        tick();
        d_wait = 30;
        req_valid = 4'b1111;
        wait_ready(5, g);
        chk("to_grant", 64'(g), 64'b1000);
        wait_done(40, g, lat);
        chk("to_done", 64'(g), 64'b1000);
        chk("to_latency", 64'(lat), 64'd16);
        chk("to_done_error", 64'(done_error), 64'd1);
        drain = 0;
        tick(); #1;
        while (busy && drain < 50) begin
            chk("drain_no_grant", 64'(req_ready), 64'd0);
            drain++;
            tick(); #1;
        end
        chk("drain_cycles", 64'(drain), 64'd20);
        chk("after_drain_grant", 64'(req_ready), 64'b0001);
        enable = 1'b0;
        req_valid = '0;
`endif

        tick(); tick();
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
